// File: rtl/bit_serial_regfile.sv
// Bit-serial register file: streams two sources LSB-first over a WIDTH-cycle
// word operation and shifts one serial result bit per cycle into a destination.
module bit_serial_regfile #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int DISP_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_wr_en,
  input  logic              i_data_in,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [WIDTH-1:0]  i_load_data,
  output logic              o_rs_bit,
  output logic              o_rt_bit,
  output logic              o_busy,
  output logic              o_done,
  output logic [WIDTH-1:0]  o_data_display
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  rs_q, rt_q, rd_q;
  logic               wen_q;
  logic [WIDTH-1:0]   regs_q [DEPTH];
  logic [WIDTH-1:0]   regs_d [DEPTH];

  // The destination write is applied last so it overrides a source rotation
  // on the same register; rs==rt simply rotates the same value once.
  always_comb begin
    regs_d = regs_q;
    if (state_q == SHIFT) begin
      regs_d[rs_q] = {regs_q[rs_q][0], regs_q[rs_q][WIDTH-1:1]};
      regs_d[rt_q] = {regs_q[rt_q][0], regs_q[rt_q][WIDTH-1:1]};
      if (wen_q) begin
        regs_d[rd_q] = {i_data_in, regs_q[rd_q][WIDTH-1:1]};
      end
    end else if (i_load) begin
      regs_d[i_load_addr] = i_load_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (i_start && !i_load) begin
            rs_q    <= i_rs_addr;
            rt_q    <= i_rt_addr;
            rd_q    <= i_rd_addr;
            wen_q   <= i_wr_en;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rs_bit       = regs_q[rs_q][0];
  assign o_rt_bit       = regs_q[rt_q][0];
  assign o_busy         = (state_q == SHIFT);
  assign o_done         = (state_q == DONE);
  assign o_data_display = regs_q[ADDR_W'(DISP_ADDR)];

endmodule

// File: tb/tb_bit_serial_regfile.sv
// Directed + randomized checks of two bit_serial_regfile configurations against a word-level model.
module tb_bit_serial_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, wen = 1'b0, din = 1'b0, load = 1'b0, sel = 1'b0;
  logic [2:0]  rs_a = '0, rt_a = '0, rd_a = '0, ld_a = '0;
  logic [15:0] ld_d = '0;

  always #5 clk = ~clk;

  logic        a_rs, a_rt, a_busy, a_done;
  logic [7:0]  a_disp;
  logic        b_rs, b_rt, b_busy, b_done;
  logic [15:0] b_disp;

  bit_serial_regfile u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start & ~sel),
    .i_rs_addr(rs_a[1:0]), .i_rt_addr(rt_a[1:0]), .i_rd_addr(rd_a[1:0]),
    .i_wr_en(wen), .i_data_in(din), .i_load(load & ~sel),
    .i_load_addr(ld_a[1:0]), .i_load_data(ld_d[7:0]),
    .o_rs_bit(a_rs), .o_rt_bit(a_rt), .o_busy(a_busy), .o_done(a_done),
    .o_data_display(a_disp)
  );

  bit_serial_regfile #(.WIDTH(16), .DEPTH(8), .DISP_ADDR(5)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start & sel),
    .i_rs_addr(rs_a), .i_rt_addr(rt_a), .i_rd_addr(rd_a),
    .i_wr_en(wen), .i_data_in(din), .i_load(load & sel),
    .i_load_addr(ld_a), .i_load_data(ld_d),
    .o_rs_bit(b_rs), .o_rt_bit(b_rt), .o_busy(b_busy), .o_done(b_done),
    .o_data_display(b_disp)
  );

  logic        m_rs, m_rt, m_busy, m_done;
  logic [15:0] m_disp;
  assign m_rs   = sel ? b_rs   : a_rs;
  assign m_rt   = sel ? b_rt   : a_rt;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_disp = sel ? b_disp : {8'h00, a_disp};

  int total = 0;
  int bad = 0;
  int W = 8;
  int depth = 4;
  int disp = 0;
  logic [15:0] mdl [8];

  int          cur_rs, cur_rt, cur_rd;
  bit          cur_w;
  logic [31:0] cur_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wmask();
    return (32'd1 << W) - 32'd1;
  endfunction

  // Display value after k shift cycles, from the operation's word-level meaning.
  function automatic logic [31:0] disp_exp(input int k, input logic [15:0] o);
    logic [31:0] ov, v;
    ov = {16'h0, o};
    if (cur_w && cur_rd == disp)
      v = (ov >> k) | ((cur_data & ((32'd1 << k) - 32'd1)) << (W - k));
    else if (cur_rs == disp || cur_rt == disp)
      v = (ov >> k) | (ov << (W - k));
    else
      v = ov;
    return v & wmask();
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
  endtask

  task automatic idle_step();
    @(posedge clk); #1;
    chk("idle_busy", 32'(m_busy), 0);
    chk("idle_done", 32'(m_done), 0);
  endtask

  task automatic do_load(input int addr, input logic [15:0] data, input bit with_start);
    load = 1'b1; start = with_start; ld_a = 3'(addr); ld_d = data;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    mdl[addr] = data & 16'(wmask());
    chk("load_busy", 32'(m_busy), 0);
    chk("load_disp", 32'(m_disp), 32'(mdl[disp]));
  endtask

  // Caller sits just after an edge in IDLE or DONE; returns in the DONE cycle.
  task automatic run_op(input int rs, input int rt, input int rd, input bit w,
                        input logic [15:0] data, input bit noise, input int abort_at);
    logic [15:0] o_rs, o_rt, o_d;
    o_rs = mdl[rs]; o_rt = mdl[rt]; o_d = mdl[disp];
    cur_rs = rs; cur_rt = rt; cur_rd = rd; cur_w = w;
    cur_data = {16'h0, data} & wmask();
    start = 1'b1; load = 1'b0; wen = w;
    rs_a = 3'(rs); rt_a = 3'(rt); rd_a = 3'(rd);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      chk("sh_busy", 32'(m_busy), 1);
      chk("sh_done", 32'(m_done), 0);
      chk("sh_rs_bit", 32'(m_rs), 32'(o_rs[k]));
      chk("sh_rt_bit", 32'(m_rt), 32'(o_rt[k]));
      chk("sh_disp", 32'(m_disp), disp_exp(k, o_d));
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        chk("rst_busy", 32'(m_busy), 0);
        chk("rst_done", 32'(m_done), 0);
        chk("rst_rs_bit", 32'(m_rs), 0);
        chk("rst_rt_bit", 32'(m_rt), 0);
        chk("rst_disp", 32'(m_disp), 0);
        return;
      end
      din = data[k];
      if (noise && k == 2) begin
        start = 1'b1; load = 1'b1; ld_a = 3'($urandom); ld_d = 16'($urandom);
      end
      if (noise && k == 3) begin
        start = 1'b0; load = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (w) mdl[rd] = data & 16'(wmask());
    chk("done_busy", 32'(m_busy), 0);
    chk("done_pulse", 32'(m_done), 1);
    chk("done_disp", 32'(m_disp), disp_exp(W, o_d));
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load($urandom_range(0, depth - 1), 16'($urandom), 1'($urandom));
      end else begin
        run_op($urandom_range(0, depth - 1), $urandom_range(0, depth - 1),
               $urandom_range(0, depth - 1), 1'($urandom), 16'($urandom),
               1'($urandom), -1);
        if ($urandom_range(0, 1) == 0) idle_step();
      end
    end
    idle_step();
  endtask

  initial begin
    clear_model();
    #2;
    chk("reset_busy", 32'(m_busy), 0);
    chk("reset_done", 32'(m_done), 0);
    chk("reset_rs_bit", 32'(m_rs), 0);
    chk("reset_rt_bit", 32'(m_rt), 0);
    chk("reset_disp", 32'(m_disp), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Worked example: A5/3C sources, 0x96 serial result into reg3.
    do_load(1, 16'hA5, 1'b0);
    do_load(2, 16'h3C, 1'b0);
    chk("disp_reg0", 32'(m_disp), 0);
    run_op(1, 2, 3, 1'b1, 16'h96, 1'b0, -1);
    idle_step();
    run_op(1, 3, 2, 1'b0, 16'h00, 1'b0, -1);
    idle_step();
    chk("reg3_is_96", 32'(mdl[3]), 32'h96);

    // Same register as both sources and destination.
    do_load(1, 16'h5A, 1'b0);
    run_op(1, 1, 1, 1'b1, 16'hFF, 1'b0, -1);
    idle_step();
    run_op(1, 0, 2, 1'b0, 16'h00, 1'b0, -1);
    idle_step();

    // Write disabled with rd on the display register, then load+start collisions.
    do_load(0, 16'hC3, 1'b0);
    run_op(0, 3, 0, 1'b0, 16'h5A, 1'b0, -1);
    idle_step();
    do_load(0, 16'h77, 1'b1);
    idle_step();
    run_op(1, 2, 3, 1'b1, 16'($urandom), 1'b1, -1);
    idle_step();

    // Back-to-back starts taken in the DONE cycle.
    run_op(0, 1, 2, 1'b1, 16'($urandom), 1'b0, -1);
    run_op(2, 3, 0, 1'b1, 16'($urandom), 1'b0, -1);
    idle_step();

    // Asynchronous reset at counter 4.
    run_op(1, 2, 0, 1'b1, 16'($urandom), 1'b0, 4);
    #10 rst_n = 1'b1;
    idle_step();
    idle_step();
    idle_step();

    random_phase(25);

    sel = 1'b1; W = 16; depth = 8; disp = 5;
    clear_model();
    #1;
    chk("b_disp_reset", 32'(m_disp), 0);
    do_load(5, 16'hBEEF, 1'b0);
    do_load(6, 16'h1234, 1'b0);
    run_op(5, 6, 5, 1'b1, 16'hA5C3, 1'b0, -1);
    run_op(6, 5, 7, 1'b1, 16'h0F0F, 1'b0, -1);
    idle_step();
    random_phase(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_serial_regfile.md
Name: bit_serial_regfile

Overview:
Parametrised bit-serial general-purpose register file for the bit-serial datapath. It holds DEPTH words of WIDTH bits. It streams two source operands out LSB-first and optionally shifts one result bit per cycle into a destination register. A sequencer with a bit counter runs a full WIDTH-cycle word operation per start command, so the ALU no longer tracks bit position. Adds a parallel load path and a display tap.

Parameters:
WIDTH, 8, bits per register; must be at least 2.
DEPTH, 4, number of registers; must be a power of 2 and at least 2.
ADDR_W, $clog2(DEPTH), address width; derived, do not override.
DISP_ADDR, 0, register mirrored on o_data_display.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  begin a WIDTH-cycle serial operation.
i_rs_addr  input  ADDR_W  source A register.
i_rt_addr  input  ADDR_W  source B register.
i_rd_addr  input  ADDR_W  destination register.
i_wr_en  input  1  write enable; sampled with i_start and held for the whole operation.
i_data_in  input  1  serial result bit, LSB-first, consumed each SHIFT cycle.
i_load  input  1  parallel load request.
i_load_addr  input  ADDR_W  parallel load target.
i_load_data  input  WIDTH  parallel load value.
o_rs_bit  output  1  current LSB of the latched source A.
o_rt_bit  output  1  current LSB of the latched source B.
o_busy  output  1  high while in SHIFT.
o_done  output  1  one-cycle pulse after the final shift.
o_data_display  output  WIDTH  live contents of register DISP_ADDR.

Behaviour:
- Reset (i_rst_n=0, asynchronous): all registers, the bit counter and the latched addresses go to 0; state IDLE. o_busy=0, o_done=0, o_rs_bit=0, o_rt_bit=0, o_data_display=0. Reset mid-operation aborts the operation; the partial result is discarded because all registers clear.
- States:
  - IDLE.
  - SHIFT: bit counter runs 0..WIDTH-1.
  - DONE: lasts one cycle.
- IDLE or DONE with i_start=1 and i_load=0: latch rs, rt, rd and wr_en; clear the counter; go to SHIFT. Start is accepted in DONE to allow back-to-back operations.
- IDLE or DONE with i_load=1: write i_load_data into reg[i_load_addr] on that edge. If i_start is also high, the load wins and i_start is ignored.
- SHIFT, each cycle:
  - o_rs_bit and o_rt_bit are combinational from reg[rs][0] and reg[rt][0], pre-shift.
  - On the edge, reg[rs] rotates right by 1. reg[rt] rotates right by 1. If rs==rt, that register rotates only once.
  - If wr_en=1: reg[rd] <= {i_data_in, reg[rd][WIDTH-1:1]}. This takes precedence over a rotation when rd equals rs or rt; the source bit shown that cycle is still the pre-shift LSB.
  - If wr_en=0: reg[rd] is untouched unless it is also a source.
  - Counter increments. At counter==WIDTH-1, go to DONE.
- Result after WIDTH SHIFT cycles:
  - Source registers not written are restored to their original value.
  - reg[rd] holds the serial input word; the first bit received ends up at bit 0.
- DONE: o_done=1 for exactly one cycle; then IDLE, or SHIFT if a start is accepted.
- During SHIFT, i_start and i_load are ignored.
- o_busy=1 exactly in SHIFT. Latency: start sampled on edge t → source bit k is on the outputs in cycle t+1+k → o_done high in cycle t+WIDTH+1.
- o_data_display is reg[DISP_ADDR] combinationally, including intermediate shift values.
- Outputs outside SHIFT: o_rs_bit and o_rt_bit show reg[latched rs][0] and reg[latched rt][0]; they carry no meaning there.

Test Plan:
1. Reset, then load reg1=0xA5 and reg2=0x3C → o_data_display=0x00. Start rs=1, rt=2, rd=3, wr_en=1, i_data_in driven with 0x96 LSB-first → o_rs_bit sequence 1,0,1,0,0,1,0,1 and o_rt_bit sequence 0,0,1,1,1,1,0,0. o_busy high for 8 cycles; o_done pulse at cycle t+9. Then reg1=0xA5, reg2=0x3C, reg3=0x96.
2. Load reg1=0x5A. Start rs=1, rt=1, rd=1, wr_en=1, serial input 0xFF → source bits read 0,1,0,1,1,0,1,0; reg1=0xFF at done.
3. Start with wr_en=0, rd=0 → reg0 unchanged after done; sources restored.
4. Assert i_start and i_load together in IDLE → load performed and o_busy stays 0. Assert i_start and i_load during SHIFT → both ignored.
5. Deassert i_rst_n asynchronously at counter=4 → all outputs and registers become 0 immediately. After release: state IDLE, no o_done pulse.
6. Re-assert i_start in the DONE cycle → second operation begins without an IDLE cycle, and o_busy rises the next cycle. Repeat with WIDTH=16, DEPTH=8, DISP_ADDR=5.
